// File: rtl/cu_mc_pkg.sv
// Shared types and constants for the multi-channel control unit.
// Holds the FSM state encoding, error codes and a constant-safe clog2.
package cu_mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WRITE,
    ST_PRE,
    ST_TRIG,
    ST_WAIT,
    ST_POST,
    ST_READ
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_SPUR    = 2'd3;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/cu_fs_sync.sv
// Two-flop synchroniser for an asynchronous strobe, followed by a
// rising-edge detector; pulse is high for one clk cycle per rising edge.
module cu_fs_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/cu_mc_ctrl.sv
// Multi-channel control unit: per frame, cycles each active channel through
// write / FA trigger / read, with timeout, overrun and spurious-done errors.
module cu_mc_ctrl
  import cu_mc_pkg::*;
#(
  parameter  int NUM_CH      = 8,
  parameter  int CNT_PRE_FA  = 3,
  parameter  int CNT_POST_FA = 3,
  parameter  int FA_TIMEOUT  = 255,
  localparam int CH_W        = clog2(NUM_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_fs,
  input  logic [CH_W:0]   num_ch,
  input  logic            fa_done,
  input  logic            err_clr,
  output logic            dly_strb,
  output logic            fa_trig,
  output logic [CH_W-1:0] channel_cnt,
  output logic            wr_clk,
  output logic [CH_W-1:0] wr_addr,
  output logic            rd_clk,
  output logic [CH_W-1:0] rd_addr,
  output logic            error,
  output logic [1:0]      err_code
);

  localparam int TMR_MAX_PP = (CNT_PRE_FA > CNT_POST_FA) ? CNT_PRE_FA : CNT_POST_FA;
  localparam int TMR_MAX    = (TMR_MAX_PP > FA_TIMEOUT) ? TMR_MAX_PP : FA_TIMEOUT;
  localparam int TMR_W      = clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] PRE_LAST  = TMR_W'((CNT_PRE_FA > 0) ? CNT_PRE_FA - 1 : 0);
  localparam logic [TMR_W-1:0] POST_LAST = TMR_W'((CNT_POST_FA > 0) ? CNT_POST_FA - 1 : 0);
  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(FA_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   cnt_q, cnt_d;
  logic [CH_W:0]     nch_q, nch_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              error_q, error_d;
  logic [1:0]        code_q, code_d;
  logic              fs_pulse, last_ch, ovr, tmo, spur;
  logic [1:0]        new_code;

  function automatic logic [CH_W:0] clamp_nch(input logic [CH_W:0] n);
    if (n == '0)                     return (CH_W+1)'(1);
    else if (n > (CH_W+1)'(NUM_CH))  return (CH_W+1)'(NUM_CH);
    else                             return n;
  endfunction

  cu_fs_sync u_fs_sync (
    .clk      (clk),
    .rst_n    (reset),
    .async_in (s_fs),
    .pulse    (fs_pulse)
  );

  assign last_ch = ({1'b0, cnt_q} == (nch_q - (CH_W+1)'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      nch_q   <= (CH_W+1)'(1);
      tmr_q   <= '0;
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nch_q   <= nch_d;
      tmr_q   <= tmr_d;
      error_q <= error_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo     = 1'b0;
    case (state_q)
      ST_IDLE:  if (fs_pulse) state_d = ST_START;
      ST_START: state_d = ST_WRITE;
      ST_WRITE: state_d = (CNT_PRE_FA == 0) ? ST_TRIG : ST_PRE;
      ST_PRE:   if (tmr_q == PRE_LAST) state_d = ST_TRIG;
      ST_TRIG:  state_d = ST_WAIT;
      ST_WAIT: begin
        // A done arriving on the expiry cycle wins over the timeout.
        if (fa_done) begin
          state_d = (CNT_POST_FA == 0) ? ST_READ : ST_POST;
        end else if (tmr_q == TMO_LAST) begin
          tmo     = 1'b1;
          state_d = (CNT_POST_FA == 0) ? ST_READ : ST_POST;
        end
      end
      ST_POST:  if (tmr_q == POST_LAST) state_d = ST_READ;
      ST_READ:  state_d = last_ch ? ST_IDLE : ST_WRITE;
      default:  state_d = ST_IDLE;
    endcase
    ovr  = fs_pulse && (state_q != ST_IDLE);
    spur = fa_done && (state_q != ST_WAIT);
    if (ovr) state_d = ST_START;
  end

  always_comb begin
    cnt_d = cnt_q;
    nch_d = nch_q;
    if (state_q == ST_START) begin
      cnt_d = '0;
      nch_d = clamp_nch(num_ch);
    end else if (state_q == ST_READ && !last_ch) begin
      cnt_d = cnt_q + CH_W'(1);
    end

    // One timer serves PRE, WAIT and POST; it restarts on every state change.
    if (state_d != state_q)
      tmr_d = '0;
    else if (state_q == ST_PRE || state_q == ST_WAIT || state_q == ST_POST)
      tmr_d = tmr_q + TMR_W'(1);
    else
      tmr_d = tmr_q;

    new_code = ovr ? ERR_OVERRUN : (tmo ? ERR_TIMEOUT : ERR_SPUR);
    error_d  = error_q;
    code_d   = code_q;
    if (err_clr) begin
      error_d = 1'b0;
      code_d  = ERR_NONE;
    end
    if ((ovr || tmo || spur) && (!error_q || err_clr)) begin
      error_d = 1'b1;
      code_d  = new_code;
    end
  end

  always_comb begin
    dly_strb    = (state_q == ST_START);
    wr_clk      = (state_q == ST_WRITE);
    fa_trig     = (state_q == ST_TRIG);
    rd_clk      = (state_q == ST_READ);
    channel_cnt = cnt_q;
    wr_addr     = cnt_q;
    rd_addr     = cnt_q;
    error       = error_q;
    err_code    = code_q;
  end

endmodule

// File: tb/tb_cu_mc_ctrl.sv
// Directed bench for cu_mc_ctrl: logs strobe times per clk edge and
// compares them with hand-derived cycle offsets for each scenario.
module tb_cu_mc_ctrl;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;

  logic            clk = 1'b0;
  logic            reset, s_fs, fa_done, err_clr;
  logic [CH_W:0]   num_ch;
  logic            dly_strb, fa_trig, wr_clk, rd_clk, error;
  logic [CH_W-1:0] channel_cnt, wr_addr, rd_addr;
  logic [1:0]      err_code;

  int vectors = 0;
  int miscompares = 0;
  int t = 0;
  bit auto_done = 1'b0;
  bit prev_trig = 1'b0;
  int dly_q[$], trig_q[$], wr_t[$], wr_a[$], rd_t[$], rd_a[$];

  cu_mc_ctrl #(.NUM_CH(NUM_CH), .CNT_PRE_FA(3), .CNT_POST_FA(3), .FA_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .s_fs(s_fs), .num_ch(num_ch), .fa_done(fa_done),
    .err_clr(err_clr), .dly_strb(dly_strb), .fa_trig(fa_trig), .channel_cnt(channel_cnt),
    .wr_clk(wr_clk), .wr_addr(wr_addr), .rd_clk(rd_clk), .rd_addr(rd_addr),
    .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // t = number of rising edges seen; fa_done answers one cycle after fa_trig.
  task automatic tick();
    @(posedge clk);
    #1;
    t++;
    if (auto_done) fa_done = prev_trig;
    prev_trig = fa_trig;
    if (dly_strb) dly_q.push_back(t);
    if (fa_trig)  trig_q.push_back(t);
    if (wr_clk) begin wr_t.push_back(t); wr_a.push_back(int'(wr_addr)); end
    if (rd_clk) begin rd_t.push_back(t); rd_a.push_back(int'(rd_addr)); end
  endtask

  task automatic clear_logs();
    dly_q.delete(); trig_q.delete(); wr_t.delete(); wr_a.delete(); rd_t.delete(); rd_a.delete();
  endtask

  task automatic fs_edge(output int ft);
    ft = t;
    s_fs = 1'b1;
    repeat (6) tick();
    s_fs = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] outs;
    reset = 1'b0; s_fs = 1'b0; fa_done = 1'b0; err_clr = 1'b0; num_ch = '0;
    repeat (3) tick();
    outs = {dly_strb, fa_trig, channel_cnt, wr_clk, wr_addr, rd_clk, rd_addr, error, err_code};
    vectors++; if (outs !== 16'h0) begin miscompares++; $display("FAIL reset_outputs: got %h want 0000", outs); end
    reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic_frame();
    int ft, d;
    clear_logs(); num_ch = 4'd2; auto_done = 1'b1;
    fs_edge(ft);
    repeat (40) tick();
    d = ft + 3;
    vectors++; if (dly_q.size() !== 1) begin miscompares++; $display("FAIL basic_dly_count: got %0d want 1", dly_q.size()); end
    vectors++; if (dly_q[0] !== d) begin miscompares++; $display("FAIL basic_dly_time: got %0d want %0d", dly_q[0], d); end
    vectors++; if (wr_t.size() !== 2) begin miscompares++; $display("FAIL basic_wr_count: got %0d want 2", wr_t.size()); end
    vectors++; if (wr_t[0] !== d + 1 || wr_a[0] !== 0) begin miscompares++; $display("FAIL basic_wr0: got t=%0d a=%0d want t=%0d a=0", wr_t[0], wr_a[0], d + 1); end
    vectors++; if (wr_t[1] !== d + 11 || wr_a[1] !== 1) begin miscompares++; $display("FAIL basic_wr1: got t=%0d a=%0d want t=%0d a=1", wr_t[1], wr_a[1], d + 11); end
    vectors++; if (trig_q[0] !== d + 5) begin miscompares++; $display("FAIL basic_trig0: got %0d want %0d", trig_q[0], d + 5); end
    vectors++; if (trig_q[1] !== d + 15) begin miscompares++; $display("FAIL basic_trig1: got %0d want %0d", trig_q[1], d + 15); end
    vectors++; if (rd_t[0] !== d + 10 || rd_a[0] !== 0) begin miscompares++; $display("FAIL basic_rd0: got t=%0d a=%0d want t=%0d a=0", rd_t[0], rd_a[0], d + 10); end
    vectors++; if (rd_t[1] !== d + 20 || rd_a[1] !== 1) begin miscompares++; $display("FAIL basic_rd1: got t=%0d a=%0d want t=%0d a=1", rd_t[1], rd_a[1], d + 20); end
    vectors++; if (rd_t.size() !== 2) begin miscompares++; $display("FAIL basic_rd_count: got %0d want 2", rd_t.size()); end
    vectors++; if (error !== 1'b0 || channel_cnt !== 3'd1) begin miscompares++; $display("FAIL basic_idle: got err=%0d cnt=%0d want err=0 cnt=1", error, channel_cnt); end
  endtask

  task automatic test_clamp();
    int ft;
    clear_logs(); num_ch = 4'd0; auto_done = 1'b1;
    fs_edge(ft);
    repeat (25) tick();
    vectors++; if (wr_t.size() !== 1 || rd_t.size() !== 1) begin miscompares++; $display("FAIL clamp0_count: got wr=%0d rd=%0d want 1/1", wr_t.size(), rd_t.size()); end
    vectors++; if (rd_t[0] !== ft + 13 || rd_a[0] !== 0) begin miscompares++; $display("FAIL clamp0_rd: got t=%0d a=%0d want t=%0d a=0", rd_t[0], rd_a[0], ft + 13); end
    clear_logs(); num_ch = (CH_W+1)'(NUM_CH + 3);
    fs_edge(ft);
    repeat (90) tick();
    vectors++; if (wr_t.size() !== NUM_CH || rd_t.size() !== NUM_CH) begin miscompares++; $display("FAIL clampmax_count: got wr=%0d rd=%0d want %0d", wr_t.size(), rd_t.size(), NUM_CH); end
    vectors++; if (rd_a[NUM_CH-1] !== NUM_CH - 1 || rd_t[NUM_CH-1] !== ft + 83) begin miscompares++; $display("FAIL clampmax_last_rd: got a=%0d t=%0d want a=%0d t=%0d", rd_a[NUM_CH-1], rd_t[NUM_CH-1], NUM_CH - 1, ft + 83); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL clamp_error: got %0d want 0", error); end
  endtask

  task automatic test_timeout();
    int ft;
    clear_logs(); num_ch = 4'd2; auto_done = 1'b0; fa_done = 1'b0;
    fs_edge(ft);
    repeat (45) tick();
    vectors++; if (rd_t.size() !== 2) begin miscompares++; $display("FAIL tmo_rd_count: got %0d want 2", rd_t.size()); end
    vectors++; if (trig_q[0] !== ft + 8) begin miscompares++; $display("FAIL tmo_trig0: got %0d want %0d", trig_q[0], ft + 8); end
    vectors++; if (rd_t[0] !== trig_q[0] + 12) begin miscompares++; $display("FAIL tmo_rd0: got %0d want %0d", rd_t[0], trig_q[0] + 12); end
    vectors++; if (rd_t[1] !== trig_q[1] + 12) begin miscompares++; $display("FAIL tmo_rd1: got %0d want %0d", rd_t[1], trig_q[1] + 12); end
    vectors++; if (error !== 1'b1 || err_code !== 2'd1) begin miscompares++; $display("FAIL tmo_err: got err=%0d code=%0d want 1/1", error, err_code); end
    pulse_clr();
    vectors++; if (error !== 1'b0 || err_code !== 2'd0) begin miscompares++; $display("FAIL tmo_clear: got err=%0d code=%0d want 0/0", error, err_code); end
  endtask

  task automatic test_overrun();
    int ft, fs2;
    clear_logs(); num_ch = 4'd2; auto_done = 1'b1;
    fs_edge(ft);
    while (t < ft + 15) tick();
    fs2 = t; s_fs = 1'b1; auto_done = 1'b0; fa_done = 1'b0;
    repeat (6) tick();
    s_fs = 1'b0;
    repeat (45) tick();
    vectors++; if (dly_q.size() !== 2 || dly_q[1] !== fs2 + 3) begin miscompares++; $display("FAIL ovr_dly: got n=%0d t=%0d want n=2 t=%0d", dly_q.size(), dly_q[1], fs2 + 3); end
    vectors++; if (wr_t[2] !== fs2 + 4 || wr_a[2] !== 0) begin miscompares++; $display("FAIL ovr_restart_wr: got t=%0d a=%0d want t=%0d a=0", wr_t[2], wr_a[2], fs2 + 4); end
    vectors++; if (trig_q.size() !== 3 || rd_t.size() !== 3) begin miscompares++; $display("FAIL ovr_counts: got trig=%0d rd=%0d want 3/3", trig_q.size(), rd_t.size()); end
    vectors++; if (rd_t[1] !== trig_q[1] + 12) begin miscompares++; $display("FAIL ovr_tmo_rd: got %0d want %0d", rd_t[1], trig_q[1] + 12); end
    vectors++; if (error !== 1'b1 || err_code !== 2'd2) begin miscompares++; $display("FAIL ovr_err: got err=%0d code=%0d want 1/2", error, err_code); end
    pulse_clr();
  endtask

  task automatic test_spurious_clear();
    int ft, d;
    auto_done = 1'b0;
    fa_done = 1'b1; tick(); fa_done = 1'b0;
    vectors++; if (error !== 1'b1 || err_code !== 2'd3) begin miscompares++; $display("FAIL spur_err: got err=%0d code=%0d want 1/3", error, err_code); end
    clear_logs(); num_ch = 4'd1;
    fs_edge(ft); d = ft + 3;
    while (t < d + 13) tick();
    vectors++; if (err_code !== 2'd3) begin miscompares++; $display("FAIL spur_held: got code=%0d want 3", err_code); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    vectors++; if (error !== 1'b1 || err_code !== 2'd1) begin miscompares++; $display("FAIL clr_vs_tmo: got err=%0d code=%0d want 1/1", error, err_code); end
    repeat (10) tick();
    vectors++; if (rd_t.size() !== 1 || rd_t[0] !== d + 17) begin miscompares++; $display("FAIL clr_tmo_rd: got n=%0d t=%0d want n=1 t=%0d", rd_t.size(), rd_t[0], d + 17); end
    pulse_clr();
    clear_logs();
    fs_edge(ft); d = ft + 3;
    while (t < d + 13) tick();
    fa_done = 1'b1; tick(); fa_done = 1'b0;
    repeat (10) tick();
    vectors++; if (error !== 1'b0 || err_code !== 2'd0) begin miscompares++; $display("FAIL done_at_expiry_err: got err=%0d code=%0d want 0/0", error, err_code); end
    vectors++; if (rd_t[0] !== d + 17) begin miscompares++; $display("FAIL done_at_expiry_rd: got %0d want %0d", rd_t[0], d + 17); end
  endtask

  task automatic test_reset_midframe();
    int ft, d;
    logic [15:0] outs;
    auto_done = 1'b0;
    fa_done = 1'b1; tick(); fa_done = 1'b0;
    clear_logs(); num_ch = 4'd2; auto_done = 1'b1;
    fs_edge(ft); d = ft + 3;
    while (t < d + 12) tick();
    auto_done = 1'b0; fa_done = 1'b0;
    while (t < d + 17) tick();
    vectors++; if (channel_cnt !== 3'd1 || error !== 1'b1) begin miscompares++; $display("FAIL rst_pre_state: got cnt=%0d err=%0d want 1/1", channel_cnt, error); end
    reset = 1'b0;
    #1;
    outs = {dly_strb, fa_trig, channel_cnt, wr_clk, wr_addr, rd_clk, rd_addr, error, err_code};
    vectors++; if (outs !== 16'h0) begin miscompares++; $display("FAIL rst_async_outputs: got %h want 0000", outs); end
    repeat (2) tick();
    reset = 1'b1;
    clear_logs();
    repeat (30) tick();
    vectors++; if (dly_q.size() + wr_t.size() + trig_q.size() + rd_t.size() !== 0) begin miscompares++; $display("FAIL rst_quiet: got %0d strobes want 0", dly_q.size() + wr_t.size() + trig_q.size() + rd_t.size()); end
    auto_done = 1'b1;
    fs_edge(ft);
    repeat (10) tick();
    vectors++; if (dly_q[0] !== ft + 3 || wr_a[0] !== 0) begin miscompares++; $display("FAIL rst_next_frame: got dly=%0d a=%0d want dly=%0d a=0", dly_q[0], wr_a[0], ft + 3); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_clamp();
    test_timeout();
    test_overrun();
    test_spurious_clear();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cu_mc_ctrl.md
Name: cu_mc_ctrl

Overview:
Parametrised multi-channel control unit for the mcac_sr datapath. It is the successor to the fixed 8-channel CU.
- Sequences per-frame, per-channel write / filter-accelerator (FA) trigger / read cycles after each frame sync.
- Channel count is selectable at run time up to a build-time maximum.
- Pre/post FA delays are parametrised.
- Adds FA-done timeout, frame-overrun and spurious-done detection with a sticky, clearable error code.

Parameters:
NUM_CH, 8, maximum channel count (>=2); CH_W = clog2(NUM_CH) is derived, not overridable
CNT_PRE_FA, 3, clk cycles between the write pulse and fa_trig (0 allowed)
CNT_POST_FA, 3, clk cycles between fa_done and the read pulse (0 allowed)
FA_TIMEOUT, 255, max cycles waiting for fa_done (1..1023)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
s_fs  in  1  frame sync, asynchronous to clk
num_ch  in  CH_W+1  active channel count, sampled at frame start
fa_done  in  1  FA completion, 1-cycle pulse
err_clr  in  1  clears error/err_code
dly_strb  out  1  frame-start strobe, 1 cycle
fa_trig  out  1  FA start, 1 cycle
channel_cnt  out  CH_W  current channel index
wr_clk  out  1  write strobe, 1 cycle
wr_addr  out  CH_W  write address (= channel_cnt)
rd_clk  out  1  read strobe, 1 cycle
rd_addr  out  CH_W  read address (= channel_cnt)
error  out  1  sticky error flag
err_code  out  2  first error: 0 none, 1 timeout, 2 overrun, 3 spurious done

Behaviour:
Reset:
- All outputs are 0 and the FSM is in IDLE.
- All outputs are registered; strobes are decoded from the state register.

Frame-sync synchroniser:
- s_fs passes through a 2-flop synchroniser followed by a rising-edge detect register, producing fs_pulse.
- dly_strb is high in the 3rd cycle after the first clk edge that samples s_fs high.

FSM states: IDLE, START, WRITE, PRE, TRIG, WAIT, POST, READ.
- IDLE: on fs_pulse -> START.
- START: dly_strb=1.
  - Latch num_ch into nch_l, clamped: 0 -> 1, >NUM_CH -> NUM_CH.
  - channel_cnt=0.
  - -> WRITE.
- WRITE: wr_clk=1 for 1 cycle -> PRE (or -> TRIG if CNT_PRE_FA=0).
- PRE: stays exactly CNT_PRE_FA cycles -> TRIG.
- TRIG: fa_trig=1 for 1 cycle; clear the timeout counter -> WAIT.
- WAIT: fa_done sampled high -> POST (or -> READ if CNT_POST_FA=0).
  - After FA_TIMEOUT WAIT cycles without fa_done: raise timeout -> POST (frame continues).
- POST: stays exactly CNT_POST_FA cycles -> READ.
- READ: rd_clk=1 for 1 cycle.
  - If channel_cnt == nch_l-1 -> IDLE.
  - Else channel_cnt+1 -> WRITE.
- channel_cnt holds its value in IDLE; it changes only in START and READ.

Per-channel cycle count, with fa_done in the first WAIT cycle: 2 + CNT_PRE_FA + 1 + CNT_POST_FA + 1 (=10 with defaults).

Boundary conditions:
- fs_pulse in any state other than IDLE:
  - Raise overrun.
  - Abort the frame and go to START next cycle. A trig already issued is not cancelled.
- fa_done outside WAIT: ignored; raise spurious done.
- fa_done on the same cycle the timeout expires: treated as done; no error.

Error handling:
- error is set by any raised error and held until err_clr.
- err_code records only the first error since the last clear.
- A new error in the same cycle as err_clr wins: error=1, err_code = the new code.
- Simultaneous errors use priority overrun > timeout > spurious.

Decomposition:
- Package cu_mc_pkg holds:
  - the state enum;
  - err_code constants ERR_NONE/TIMEOUT/OVERRUN/SPUR;
  - a clog2 function.
- Sub-module cu_fs_sync: 2-flop synchroniser plus rising-edge detect. It is reused for any async strobe and has async active-low reset.
- The FSM and counters live in cu_mc_ctrl.

Test Plan:
- Basic frame: defaults, num_ch=2, one s_fs edge, fa_done 1 cycle after each fa_trig.
  - Expect dly_strb 3 cycles after s_fs.
  - Expect wr_addr 0 then 1, rd_addr 0 then 1.
  - fa_trig occurs 4 cycles after each wr_clk; rd_clk 4 cycles after each fa_done.
  - Back to IDLE 21 cycles after dly_strb; error=0.
- Clamp: num_ch=0 -> exactly 1 channel processed. num_ch=NUM_CH+3 -> NUM_CH channels, last rd_addr=NUM_CH-1.
- Timeout: FA_TIMEOUT=8, fa_done never asserted.
  - Expect rd_clk per channel 8+CNT_POST_FA cycles after fa_trig+1.
  - error=1, err_code=1.
- Overrun: second s_fs edge mid-channel 1.
  - Expect err_code=2 and dly_strb again.
  - channel_cnt restarts at 0.
  - Subsequent timeout does not change err_code.
- Spurious done and clear: fa_done pulsed in IDLE -> err_code=3. err_clr the same cycle as a new timeout -> error stays 1, err_code=1.
- Reset mid-frame: assert reset during WAIT -> all outputs 0 immediately (async). After release, no activity until the next s_fs edge.
